karatsuba_mult_seq: RTL and testbench

- Parametrised, multi-cycle unsigned Karatsuba multiplier. It is the sequential successor to the 2-bit combinational karatsuba2.
- Splits each WIDTH-bit operand into halves. Computes the three Karatsuba partial products one per cycle on a single shared (H+1)x(H+1) multiplier, where H = WIDTH/2, then recombines them.
- Valid/ready handshakes on both sides, so it drops into the accelerator datapath between an operand FIFO and the accumulator.

---
 rtl/karatsuba_mult_seq.sv | 124 ++++++++++++
 tb/tb_karatsuba_mult_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mult_seq.sv
// Sequential unsigned Karatsuba multiplier: three half-width partial products computed one per
// cycle on a single shared (H+1)x(H+1) multiplier, then recombined, with valid/ready on both sides.
module karatsuba_mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     inx,
  input  logic [WIDTH-1:0]     iny,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int unsigned H = WIDTH / 2;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("karatsuba_mult_seq: WIDTH must be even and >= 4");
  end

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StMulHi   = 3'd1;
  localparam logic [2:0] StMulLo   = 3'd2;
  localparam logic [2:0] StMulMid  = 3'd3;
  localparam logic [2:0] StCombine = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [2*H-1:0]     z2_q, z0_q;
  logic [2*H+1:0]     zm_q;
  logic [2*WIDTH-1:0] out_q;
  logic               out_valid_q;

  logic [H-1:0]       xh, xl, yh, yl;
  logic [H:0]         mul_a, mul_b;
  logic [2*H+1:0]     mul_p;
  logic [2*H+1:0]     z1;
  logic [2*WIDTH-1:0] combined;

  assign xh = x_q[WIDTH-1:H];
  assign xl = x_q[H-1:0];
  assign yh = y_q[WIDTH-1:H];
  assign yl = y_q[H-1:0];

  // Shared multiplier; operands chosen by state. Half sums keep their carry bit.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMulHi: begin
        mul_a = {1'b0, xh};
        mul_b = {1'b0, yh};
      end
      StMulLo: begin
        mul_a = {1'b0, xl};
        mul_b = {1'b0, yl};
      end
      StMulMid: begin
        mul_a = {1'b0, xh} + {1'b0, xl};
        mul_b = {1'b0, yh} + {1'b0, yl};
      end
      default: ;
    endcase
  end

  assign mul_p = {{(H + 1){1'b0}}, mul_a} * {{(H + 1){1'b0}}, mul_b};

  // z2 and z0 occupy disjoint bit ranges, so concatenation stands in for the first addition.
  assign z1       = zm_q - {2'b00, z2_q} - {2'b00, z0_q};
  assign combined = {z2_q, z0_q} + ({{(2 * WIDTH - 2 * H - 2){1'b0}}, z1} << H);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (in_valid) state_d = StMulHi;
      StMulHi:   state_d = StMulLo;
      StMulLo:   state_d = StMulMid;
      StMulMid:  state_d = StCombine;
      StCombine: state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      z2_q        <= '0;
      z0_q        <= '0;
      zm_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q <= inx;
            y_q <= iny;
          end
        end
        StMulHi:   z2_q <= mul_p[2*H-1:0];
        StMulLo:   z0_q <= mul_p[2*H-1:0];
        StMulMid:  zm_q <= mul_p;
        StCombine: begin
          out_q       <= combined;
          out_valid_q <= 1'b1;
        end
        StDone:    if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_karatsuba_mult_seq.sv
// Directed bench for karatsuba_mult_seq at WIDTH=4 (exhaustive), WIDTH=8 and WIDTH=16.
module tb_karatsuba_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=16 instance
  logic        v16 = 1'b0, r16, ov16, ordy16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;
  logic [31:0] o16;
  // WIDTH=8 instance
  logic        v8 = 1'b0, r8, ov8, ordy8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [15:0] o8;
  // WIDTH=4 instance
  logic        v4 = 1'b0, r4, ov4, ordy4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  o4;

  karatsuba_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .inx(x16), .iny(y16),
    .out_valid(ov16), .out_ready(ordy16), .out(o16)
  );
  karatsuba_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .inx(x8), .iny(y8),
    .out_valid(ov8), .out_ready(ordy8), .out(o8)
  );
  karatsuba_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .inx(x4), .iny(y4),
    .out_valid(ov4), .out_ready(ordy4), .out(o4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one pair on the 16-bit unit, wait for the product, check value and latency.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
    int n;
    logic busy_ok;
    @(negedge clk);
    x16 = a; y16 = b; v16 = 1'b1; ordy16 = 1'b1;
    check({tag, "_ready"}, 64'(r16), 64'd1);
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0;
    n = 0; busy_ok = 1'b1;
    while (!ov16 && n < 20) begin
      if (r16) busy_ok = 1'b0;
      @(posedge clk); n++; @(negedge clk);
    end
    check({tag, "_lat"}, 64'(n), 64'd4);
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_out"}, 64'(o16), 64'(exp));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hs"}, 64'({ov16, r16}), 64'b01);
  endtask

  logic [7:0]  bx8 [3];
  logic [7:0]  by8 [3];
  logic [15:0] be8 [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic busy_ok;
    logic [31:0] saved;

    // Reset state
    #2;
    check("rst_ready", 64'(r16), 64'd0);
    check("rst_valid", 64'(ov16), 64'd0);
    check("rst_out", 64'(o16), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'({r16, r8, r4}), 64'b111);

    // Main vectors at WIDTH=16
    run16("carry", 16'h1234, 16'hABCD, 32'h0C374FA4);
    run16("ones", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16("zero", 16'h0000, 16'hBEEF, 32'h00000000);
    check("zero_kept", 64'(o16), 64'd0);

    // Backpressure
    @(negedge clk);
    x16 = 16'h00FF; y16 = 16'h0100; v16 = 1'b1; ordy16 = 1'b0;
    @(posedge clk); @(negedge clk);
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    check("bp_lat", 64'(n), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold", 64'({ov16, r16, o16}), {30'd0, 2'b10, 32'h0000FF00});
    end
    ordy16 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release", 64'({ov16, r16}), 64'b01);
    check("bp_out_kept", 64'(o16), 64'h0000FF00);

    // Ignore while busy: inputs change after accept, in_valid stays high
    x16 = 16'h1234; y16 = 16'hABCD; v16 = 1'b1; ordy16 = 1'b0;
    @(posedge clk); @(negedge clk);
    x16 = 16'h0003; y16 = 16'h0005;
    n = 0;
    while (!ov16 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    check("busy_first", 64'(o16), 64'h0C374FA4);
    @(posedge clk); @(negedge clk);
    check("busy_still_done", 64'({ov16, o16}), {31'd0, 1'b1, 32'h0C374FA4});
    ordy16 = 1'b1;
    @(posedge clk); @(negedge clk);   // DONE -> IDLE
    check("busy_idle", 64'(r16), 64'd1);
    @(posedge clk); @(negedge clk);   // second pair accepted here
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    check("busy_second_lat", 64'(n), 64'd4);
    check("busy_second", 64'(o16), 64'd15);
    @(posedge clk); @(negedge clk);

    // Reset during MUL_MID
    x16 = 16'h1234; y16 = 16'hABCD; v16 = 1'b1; ordy16 = 1'b1;
    @(posedge clk); @(negedge clk);   // MUL_HI
    v16 = 1'b0;
    @(posedge clk); @(negedge clk);   // MUL_LO
    @(posedge clk); @(negedge clk);   // MUL_MID
    saved = o16;
    check("pre_rst_out", 64'(saved), 64'd15);
    rst = 1'b1;
    #1;
    check("midrst", 64'({ov16, r16, o16}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(r16), 64'd1);
    run16("after_rst", 16'd3, 16'd5, 32'd15);

    // Back-to-back at WIDTH=8
    bx8[0] = 8'hFF; by8[0] = 8'hFF; be8[0] = 16'hFE01;
    bx8[1] = 8'h80; by8[1] = 8'h02; be8[1] = 16'h0100;
    bx8[2] = 8'h0F; by8[2] = 8'hF0; be8[2] = 16'h0E10;
    @(negedge clk);
    v8 = 1'b1; ordy8 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      x8 = bx8[j]; y8 = by8[j];
      n = 0;
      while (!r8 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      check("b2b_ready", 64'(r8), 64'd1);
      @(posedge clk); @(negedge clk);
      n = 0;
      while (!ov8 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      check("b2b_lat", 64'(n), 64'd4);
      check("b2b_out", 64'(o8), 64'(be8[j]));
    end
    v8 = 1'b0;

    // Exhaustive at WIDTH=4
    ordy4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        x4 = 4'(a); y4 = 4'(b); v4 = 1'b1;
        @(posedge clk); @(negedge clk);
        v4 = 1'b0;
        n = 0; busy_ok = 1'b1;
        while (!ov4 && n < 20) begin
          if (r4) busy_ok = 1'b0;
          @(posedge clk); n++; @(negedge clk);
        end
        check("w4_lat", 64'(n), 64'd4);
        check("w4_busy", 64'(busy_ok), 64'd1);
        check("w4_out", 64'(o4), 64'(a * b));
        @(posedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
